systolic_array_v2: RTL and testbench
====================================

SYSTOLIC_ARRAY_V2 -- requirements
Module: systolic_array_v2

Interface
REQ-001 Parameter rows, 64, PE array row count (>=1).
REQ-002 Parameter cols, 64, PE array column count (>=1).
REQ-003 Parameter ip_width, 8, operand width.
REQ-004 Parameter op_width, 32, accumulator/result width (>= 2*ip_width).
REQ-005 Parameter pipe_lat, 3, multiply pipeline depth in cycles (>=1).
REQ-006 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-007 Port rst  in  1  reset, asynchronous, active-low.
REQ-008 Port en  in  1  feed token valid this cycle.
REQ-009 Port clr  in  1  with first token of a job: zero accumulators before adding.
REQ-010 Port signed_mode  in  1  1 = two's-complement operands; 0 = unsigned.
REQ-011 Port sat_en  in  1  1 = saturate accumulation; 0 = wrap modulo 2^op_width.
REQ-012 Port input_matrix  in  rows*ip_width  A column; row r at [r*ip_width +: ip_width].
REQ-013 Port weight_matrix  in  cols*ip_width  W row; column c at [c*ip_width +: ip_width].
REQ-014 Port busy  out  1  high in FEED or DRAIN.
REQ-015 Port compute_done  out  1  level; high in DONE.
REQ-016 Port overflow  out  1  sticky; any PE saturated or wrapped this job.
REQ-017 Port protocol_err  out  1  sticky; en seen during DRAIN.
REQ-018 Port cycles_count  out  32  job cycle count.
REQ-019 Port output_matrix  out  rows*cols*op_width  C(r,c) at [(r*cols+c)*op_width +: op_width].

Function
REQ-020 The block SHALL compute C(r,c) += sum over tokens k of A_k(r)*W_k(c), output-stationary.
REQ-021 Row r operand SHALL be delayed r cycles and column c operand c cycles (skew) before entering the array; operands pass PE-to-PE with one register per hop.
REQ-022 FSM states SHALL be IDLE, FEED, DRAIN, DONE; reset state IDLE.
REQ-023 IDLE/DONE -> FEED on edge with en=1; that edge latches signed_mode and sat_en for the whole job, clears overflow, protocol_err and cycles_count.
REQ-024 If clr=1 on the FEED-entry edge, all accumulators SHALL be zeroed before the first product; clr=0 SHALL continue accumulating onto existing results (K-splitting).
REQ-025 clr while in FEED after the first token SHALL be ignored.
REQ-026 FEED -> DRAIN on first edge with en=0; the stream is one contiguous burst.
REQ-027 DRAIN SHALL last D = (rows-1)+(cols-1)+pipe_lat cycles, then -> DONE.
REQ-028 compute_done SHALL rise D+1 rising edges after the last edge sampling en=1; hold until the next FEED entry.
REQ-029 en=1 during DRAIN SHALL be ignored (no accumulation, no restart) and set protocol_err.
REQ-030 cycles_count SHALL increment every cycle in FEED and DRAIN and freeze in DONE; K-token job reads K+D+1... no: K+D.
REQ-031 Products SHALL be 2*ip_width bits, sign-extended (signed_mode=1) or zero-extended (0) to op_width.
REQ-032 With sat_en=1, accumulation SHALL clamp to op_width max/min of the latched signedness; with sat_en=0 wrap; either way an out-of-range result sets overflow.
REQ-033 output_matrix SHALL reflect accumulator registers directly; valid only while compute_done=1.

Reset
REQ-034 rst low SHALL immediately, asynchronously clear FSM to IDLE, all accumulators, skew/pipe registers, busy, compute_done, overflow, protocol_err, cycles_count and output_matrix to 0.
REQ-035 rst asserted mid-FEED or mid-DRAIN SHALL abandon the job; after release the block waits in IDLE for en.

Verification (bench config rows=cols=2, ip_width=8, op_width=32, pipe_lat=3, D=5)
REQ-036 Unsigned K=1, clr=1, A=[1,2], W=[3,4] -> C=[3,4;6,8], compute_done rises 6 edges after the token edge, cycles_count=6.
REQ-037 Signed K=1, A=[0xFF,0x02], W=[0x03,0xFC] -> C=[0xFFFFFFFD,0x00000004;0x00000006,0xFFFFFFF8], overflow=0.
REQ-038 op_width=16, unsigned, K=2, all operands 0xFF -> sat_en=1: every C=0xFFFF, overflow=1; sat_en=0: every C=0xFC02, overflow=1.
REQ-039 Job1 as REQ-036, then job2 K=1 clr=0 same data -> C=[6,8;12,16]; job3 clr=1 -> C=[3,4;6,8].
REQ-040 en pulsed 2 cycles into DRAIN -> protocol_err=1, C and done timing as REQ-036.
REQ-041 rst low 3 cycles into DRAIN -> all outputs 0 same cycle; compute_done never rises until a new job completes.

Source files
------------

// File: rtl/systolic_array_v2.sv
// Output-stationary systolic MAC array: skewed A/W operand streams, pipelined
// multipliers, per-PE saturating or wrapping accumulators, job-sequencing FSM.
module systolic_array_v2 #(
  parameter int rows     = 64,
  parameter int cols     = 64,
  parameter int ip_width = 8,
  parameter int op_width = 32,
  parameter int pipe_lat = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           clr,
  input  logic                           signed_mode,
  input  logic                           sat_en,
  input  logic [rows*ip_width-1:0]       input_matrix,
  input  logic [cols*ip_width-1:0]       weight_matrix,
  output logic                           busy,
  output logic                           compute_done,
  output logic                           overflow,
  output logic                           protocol_err,
  output logic [31:0]                    cycles_count,
  output logic [rows*cols*op_width-1:0]  output_matrix
);

  localparam int drain_len = (rows - 1) + (cols - 1) + pipe_lat;
  localparam int pw        = 2 * ip_width;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t state, state_nxt;
  logic [31:0] drain_cnt;
  logic        sgn_q, sat_q;
  logic        start, tok;

  logic [rows-1:0][ip_width-1:0] a_feed, a_skew;
  logic [cols-1:0][ip_width-1:0] w_feed, w_skew;

  logic [ip_width-1:0] a_reg   [rows][cols];
  logic [ip_width-1:0] w_reg   [rows][cols];
  logic [pw-1:0]       prod    [rows][cols][pipe_lat];
  logic [op_width-1:0] acc     [rows][cols];
  logic [op_width-1:0] acc_nxt [rows][cols];
  logic [rows*cols-1:0] pe_ovf;

  assign start = en && (state == IDLE || state == DONE);
  assign tok   = en && (state != DRAIN);

  function automatic logic [pw-1:0] mul(input logic [ip_width-1:0] a,
                                        input logic [ip_width-1:0] b,
                                        input logic sgn);
    logic [pw-1:0] xa, xb;
    xa = sgn ? {{ip_width{a[ip_width-1]}}, a} : {{ip_width{1'b0}}, a};
    xb = sgn ? {{ip_width{b[ip_width-1]}}, b} : {{ip_width{1'b0}}, b};
    return xa * xb;
  endfunction

  // Returns {overflow, next accumulator}; sum is formed one bit wider to detect range exit.
  function automatic logic [op_width:0] acc_step(input logic [op_width-1:0] a,
                                                 input logic [pw-1:0] p,
                                                 input logic sgn,
                                                 input logic sat);
    logic [op_width:0]   sum;
    logic [op_width-1:0] pext, res;
    logic                ovf;
    pext = sgn ? op_width'($signed(p)) : op_width'(p);
    if (sgn) begin
      sum = {a[op_width-1], a} + {pext[op_width-1], pext};
      ovf = sum[op_width] != sum[op_width-1];
      if (ovf && sat)
        res = sum[op_width] ? {1'b1, {(op_width-1){1'b0}}} : {1'b0, {(op_width-1){1'b1}}};
      else
        res = sum[op_width-1:0];
    end else begin
      sum = {1'b0, a} + {1'b0, pext};
      ovf = sum[op_width];
      res = (ovf && sat) ? '1 : sum[op_width-1:0];
    end
    return {ovf, res};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    busy         = 1'b0;
    compute_done = 1'b0;
    case (state)
      IDLE:  if (en) state_nxt = FEED;
      FEED:  begin
        busy = 1'b1;
        if (!en) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == 32'(drain_len - 1)) state_nxt = DONE;
      end
      DONE:  begin
        compute_done = 1'b1;
        if (en) state_nxt = FEED;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drain_cnt    <= '0;
      sgn_q        <= 1'b0;
      sat_q        <= 1'b0;
      overflow     <= 1'b0;
      protocol_err <= 1'b0;
      cycles_count <= '0;
    end else begin
      drain_cnt <= (state == DRAIN) ? drain_cnt + 32'd1 : '0;
      if (start) begin
        sgn_q        <= signed_mode;
        sat_q        <= sat_en;
        overflow     <= 1'b0;
        protocol_err <= 1'b0;
        cycles_count <= '0;
      end else begin
        if (state == FEED || state == DRAIN) cycles_count <= cycles_count + 32'd1;
        if (|pe_ovf) overflow <= 1'b1;
        if (state == DRAIN && en) protocol_err <= 1'b1;
      end
    end
  end

  // Idle tokens enter as zeros so in-flight bubbles add nothing to accumulators.
  assign a_feed = tok ? input_matrix  : '0;
  assign w_feed = tok ? weight_matrix : '0;

  for (genvar r = 0; r < rows; r++) begin : g_askew
    if (r == 0) begin : g_direct
      assign a_skew[r] = a_feed[r];
    end else begin : g_dly
      logic [ip_width-1:0] dly [r];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int unsigned i = 0; i < r; i++) dly[i] <= '0;
        end else begin
          dly[0] <= a_feed[r];
          for (int unsigned i = 1; i < r; i++) dly[i] <= dly[i-1];
        end
      end
      assign a_skew[r] = dly[r-1];
    end
  end

  for (genvar c = 0; c < cols; c++) begin : g_wskew
    if (c == 0) begin : g_direct
      assign w_skew[c] = w_feed[c];
    end else begin : g_dly
      logic [ip_width-1:0] dly [c];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int unsigned i = 0; i < c; i++) dly[i] <= '0;
        end else begin
          dly[0] <= w_feed[c];
          for (int unsigned i = 1; i < c; i++) dly[i] <= dly[i-1];
        end
      end
      assign w_skew[c] = dly[c-1];
    end
  end

  always_comb begin
    pe_ovf = '0;
    for (int unsigned r = 0; r < rows; r++)
      for (int unsigned c = 0; c < cols; c++)
        {pe_ovf[r*cols+c], acc_nxt[r][c]} =
          acc_step(acc[r][c], prod[r][c][pipe_lat-1], sgn_q, sat_q);
  end

  // Zeroing on the entry edge is safe: the first token's product lands later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < rows; r++)
        for (int unsigned c = 0; c < cols; c++) begin
          a_reg[r][c] <= '0;
          w_reg[r][c] <= '0;
          acc[r][c]   <= '0;
          for (int unsigned i = 0; i < pipe_lat; i++) prod[r][c][i] <= '0;
        end
    end else begin
      for (int unsigned r = 0; r < rows; r++) begin
        a_reg[r][0] <= a_skew[r];
        for (int unsigned c = 1; c < cols; c++) a_reg[r][c] <= a_reg[r][c-1];
      end
      for (int unsigned c = 0; c < cols; c++) begin
        w_reg[0][c] <= w_skew[c];
        for (int unsigned r = 1; r < rows; r++) w_reg[r][c] <= w_reg[r-1][c];
      end
      for (int unsigned r = 0; r < rows; r++)
        for (int unsigned c = 0; c < cols; c++) begin
          prod[r][c][0] <= mul(a_reg[r][c], w_reg[r][c], sgn_q);
          for (int unsigned i = 1; i < pipe_lat; i++) prod[r][c][i] <= prod[r][c][i-1];
          acc[r][c] <= (start && clr) ? '0 : acc_nxt[r][c];
        end
    end
  end

  always_comb begin
    output_matrix = '0;
    for (int unsigned r = 0; r < rows; r++)
      for (int unsigned c = 0; c < cols; c++)
        output_matrix[(r*cols+c)*op_width +: op_width] = acc[r][c];
  end

endmodule

// File: tb/tb_systolic_array_v2.sv
// Scoreboard bench for systolic_array_v2 (2x2, pipe_lat=3) at op_width 32 and 16;
// an integer-range reference model predicts results per job.
module tb_systolic_array_v2;

  localparam int D = 5;

  logic         clk, rst, en, clr, signed_mode, sat_en;
  logic [15:0]  input_matrix, weight_matrix;
  logic         busy, compute_done, overflow, protocol_err;
  logic [31:0]  cycles_count;
  logic [127:0] output_matrix;
  logic         busy16, done16, ovf16, perr16;
  logic [31:0]  cyc16;
  logic [63:0]  om16;

  systolic_array_v2 #(.rows(2), .cols(2), .ip_width(8), .op_width(32), .pipe_lat(3)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .signed_mode(signed_mode), .sat_en(sat_en),
    .input_matrix(input_matrix), .weight_matrix(weight_matrix), .busy(busy),
    .compute_done(compute_done), .overflow(overflow), .protocol_err(protocol_err),
    .cycles_count(cycles_count), .output_matrix(output_matrix));

  systolic_array_v2 #(.rows(2), .cols(2), .ip_width(8), .op_width(16), .pipe_lat(3)) dut16 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .signed_mode(signed_mode), .sat_en(sat_en),
    .input_matrix(input_matrix), .weight_matrix(weight_matrix), .busy(busy16),
    .compute_done(done16), .overflow(ovf16), .protocol_err(perr16),
    .cycles_count(cyc16), .output_matrix(om16));

  typedef struct {
    logic [127:0] c32;
    logic [63:0]  c16;
    bit           ovf32, ovf16, perr;
    int           cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl32 [4];
  logic [15:0] mdl16 [4];
  logic [7:0]  ta [4][2];
  logic [7:0]  tw [4][2];
  int          n_tests = 0;
  int          n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference step on true integer values: returns {out_of_range, next value}.
  function automatic logic [32:0] mstep(input logic [31:0] acc_v, input int ow, input bit sgn,
                                        input bit sat, input logic [7:0] a, input logic [7:0] w);
    longint mask, av, pa, pwt, sum, mn, mx;
    bit ov;
    mask = (longint'(1) << ow) - 1;
    av   = longint'(acc_v) & mask;
    if (sgn && av[ow-1]) av = av - (longint'(1) << ow);
    pa  = sgn ? longint'($signed(a)) : longint'(a);
    pwt = sgn ? longint'($signed(w)) : longint'(w);
    sum = av + pa * pwt;
    mn  = sgn ? -(longint'(1) << (ow - 1)) : 0;
    mx  = sgn ? (longint'(1) << (ow - 1)) - 1 : mask;
    ov  = (sum < mn) || (sum > mx);
    if (ov && sat) sum = (sum > mx) ? mx : mn;
    return {ov, 32'(sum & mask)};
  endfunction

  // mode 0: normal, 1: en pulse during DRAIN, 2: reset during DRAIN
  task automatic run_job(input int k, input bit clr_i, input bit sgn, input bit sat, input int mode);
    exp_t        e;
    logic [32:0] r;
    bit          fired, aborted, seen;
    int          lat;
    if (clr_i) for (int i = 0; i < 4; i++) begin mdl32[i] = '0; mdl16[i] = '0; end
    e.ovf32 = 0;
    e.ovf16 = 0;
    for (int t = 0; t < k; t++)
      for (int rr = 0; rr < 2; rr++)
        for (int cc = 0; cc < 2; cc++) begin
          r = mstep(mdl32[rr*2+cc], 32, sgn, sat, ta[t][rr], tw[t][cc]);
          mdl32[rr*2+cc] = r[31:0];
          e.ovf32 |= r[32];
          r = mstep({16'h0, mdl16[rr*2+cc]}, 16, sgn, sat, ta[t][rr], tw[t][cc]);
          mdl16[rr*2+cc] = r[15:0];
          e.ovf16 |= r[32];
        end
    e.c32 = '0;
    e.c16 = '0;
    for (int i = 0; i < 4; i++) begin
      e.c32[i*32 +: 32] = mdl32[i];
      e.c16[i*16 +: 16] = mdl16[i];
    end
    e.perr = (mode == 1);
    e.cyc  = k + D;
    if (mode != 2) sb.push_back(e);

    for (int t = 0; t < k; t++) begin
      @(negedge clk);
      en            = 1'b1;
      clr           = (t == 0) ? clr_i : 1'b1;
      signed_mode   = (t == 0) ? sgn : !sgn;
      sat_en        = (t == 0) ? sat : !sat;
      input_matrix  = {ta[t][1], ta[t][0]};
      weight_matrix = {tw[t][1], tw[t][0]};
    end
    @(posedge clk); #1;
    check("busy_feed", busy, 1'b1);
    @(negedge clk);
    en            = 1'b0;
    clr           = 1'b1;
    signed_mode   = !sgn;
    sat_en        = !sat;
    input_matrix  = 16'($urandom);
    weight_matrix = 16'($urandom);

    fired   = 0;
    aborted = 0;
    lat     = 0;
    for (int n = 1; n <= 40 && !fired && !aborted; n++) begin
      @(posedge clk); #1;
      if (compute_done) begin
        fired = 1;
        lat   = n;
      end else if (mode == 2 && n == 3) begin
        rst = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", compute_done, 1'b0);
        check("rst_flags", {overflow, protocol_err}, 2'b00);
        check("rst_cycles", cycles_count, 32'd0);
        check("rst_out32", output_matrix, 128'd0);
        check("rst_out16", om16, 64'd0);
        aborted = 1;
      end else begin
        en = (mode == 1 && n == 2);
      end
    end
    en = 1'b0;

    if (mode == 2) begin
      for (int i = 0; i < 4; i++) begin mdl32[i] = '0; mdl16[i] = '0; end
      repeat (3) @(negedge clk);
      rst  = 1'b1;
      seen = 0;
      repeat (12) begin
        @(posedge clk); #1;
        if (compute_done || done16) seen = 1;
      end
      check("no_done_after_rst", seen, 1'b0);
    end else begin
      check("done_latency", lat, D + 1);
      check("done16", done16, 1'b1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out32", output_matrix, e.c32);
        check("out16", om16, e.c16);
        check("ovf32", overflow, e.ovf32);
        check("ovf16", ovf16, e.ovf16);
        check("perr", protocol_err, e.perr);
        check("cycles32", cycles_count, e.cyc);
        check("cycles16", cyc16, e.cyc);
      end
      repeat (2) @(posedge clk);
      #1;
      check("done_hold", compute_done, 1'b1);
      check("cycles_frozen", cycles_count, e.cyc);
    end
  endtask

  task automatic set_base();
    ta[0][0] = 8'd1; ta[0][1] = 8'd2;
    tw[0][0] = 8'd3; tw[0][1] = 8'd4;
  endtask

  task automatic set_all(input logic [7:0] av, input logic [7:0] wv);
    for (int t = 0; t < 4; t++)
      for (int i = 0; i < 2; i++) begin
        ta[t][i] = av;
        tw[t][i] = wv;
      end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; signed_mode = 1'b0; sat_en = 1'b0;
    input_matrix = '0; weight_matrix = '0;
    #2 rst = 1'b0;
    #10;
    check("reset_busy", busy, 1'b0);
    check("reset_done", compute_done, 1'b0);
    check("reset_flags", {overflow, protocol_err}, 2'b00);
    check("reset_cycles", cycles_count, 32'd0);
    check("reset_out", output_matrix, 128'd0);
    @(negedge clk);
    rst = 1'b1;

    set_base();
    run_job(1, 1'b1, 1'b0, 1'b0, 0);
    check("basic_c", output_matrix, {32'd8, 32'd6, 32'd4, 32'd3});
    run_job(1, 1'b0, 1'b0, 1'b0, 0);
    check("ksplit_c", output_matrix, {32'd16, 32'd12, 32'd8, 32'd6});
    run_job(1, 1'b1, 1'b0, 1'b0, 0);

    ta[0][0] = 8'hFF; ta[0][1] = 8'h02;
    tw[0][0] = 8'h03; tw[0][1] = 8'hFC;
    run_job(1, 1'b1, 1'b1, 1'b0, 0);
    check("signed_c", output_matrix, {32'hFFFFFFF8, 32'h00000006, 32'h00000004, 32'hFFFFFFFD});

    set_all(8'hFF, 8'hFF);
    run_job(2, 1'b1, 1'b0, 1'b1, 0);
    check("sat16_c", om16, {4{16'hFFFF}});
    check("sat16_ovf", ovf16, 1'b1);
    run_job(2, 1'b1, 1'b0, 1'b0, 0);
    check("wrap16_c", om16, {4{16'hFC02}});
    check("wrap16_ovf", ovf16, 1'b1);

    set_all(8'h80, 8'h7F);
    run_job(3, 1'b1, 1'b1, 1'b1, 0);
    check("ssat16_c", om16, {4{16'h8000}});

    // two accumulating jobs, second with clr held high after its first token
    for (int j = 0; j < 2; j++) begin
      for (int t = 0; t < 4; t++)
        for (int i = 0; i < 2; i++) begin
          ta[t][i] = 8'($urandom);
          tw[t][i] = 8'($urandom);
        end
      run_job(4, (j == 0), 1'($urandom), 1'($urandom), 0);
    end

    set_base();
    run_job(1, 1'b1, 1'b0, 1'b0, 1);
    check("perr_c", output_matrix, {32'd8, 32'd6, 32'd4, 32'd3});

    run_job(1, 1'b1, 1'b0, 1'b0, 2);
    run_job(1, 1'b0, 1'b0, 1'b0, 0);
    check("post_rst_c", output_matrix, {32'd8, 32'd6, 32'd4, 32'd3});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
